// File: rtl/div_unit.sv
// rtl/div_unit.sv - multi-cycle radix-2 restoring divider for DIV/DIVU
// Quotient returns on lo, remainder on hi, with a one-cycle done pulse.
module div_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             signed_op,
   input  logic             cancel,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] hi,
   output logic             div_zero
);

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t           state, state_next;
   logic [CNT_W-1:0] count;
   logic [WIDTH-1:0] rem, quo, dvsr;
   logic             sign_q, sign_r;
   logic [WIDTH-1:0] a_mag, b_mag;
   logic [WIDTH:0]   shifted, diff;
   logic             accept, last_iter;

   assign accept    = start && !cancel;
   assign last_iter = (count == {CNT_W{1'b1}});
   assign a_mag     = (signed_op && a[WIDTH-1]) ? -a : a;
   assign b_mag     = (signed_op && b[WIDTH-1]) ? -b : b;
   // Partial remainder is always below the divisor, so the shifted value fits in WIDTH+1 bits.
   assign shifted   = {rem, quo[WIDTH-1]};
   assign diff      = shifted - {1'b0, dvsr};

   assign busy = (state == CALC) || (state == FIX);
   assign done = (state == DONE);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (accept) state_next = (b == '0) ? DONE : CALC;
         CALC: begin
            if (cancel)         state_next = IDLE;
            else if (last_iter) state_next = FIX;
         end
         FIX:  state_next = cancel ? IDLE : DONE;
         DONE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count    <= '0;
         rem      <= '0;
         quo      <= '0;
         dvsr     <= '0;
         sign_q   <= 1'b0;
         sign_r   <= 1'b0;
         lo       <= '0;
         hi       <= '0;
         div_zero <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  if (b == '0) begin
                     lo       <= '1;
                     hi       <= a;
                     div_zero <= 1'b1;
                  end else begin
                     count  <= '0;
                     rem    <= '0;
                     quo    <= a_mag;
                     dvsr   <= b_mag;
                     sign_q <= signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
                     sign_r <= signed_op && a[WIDTH-1];
                  end
               end
            end
            CALC: begin
               count <= count + 1'b1;
               if (!diff[WIDTH]) begin
                  rem <= diff[WIDTH-1:0];
                  quo <= {quo[WIDTH-2:0], 1'b1};
               end else begin
                  rem <= shifted[WIDTH-1:0];
                  quo <= {quo[WIDTH-2:0], 1'b0};
               end
            end
            FIX: begin
               if (!cancel) begin
                  lo       <= sign_q ? -quo : quo;
                  hi       <= sign_r ? -rem : rem;
                  div_zero <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - directed self-checking bench for div_unit
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_div_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        signed_op = 1'b0;
   logic        cancel = 1'b0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        busy, done, div_zero;
   logic [31:0] lo, hi;

   int tests = 0;
   int fails = 0;
   int n, bc;

   div_unit #(.WIDTH(32), .CNT_W(5)) dut (
      .clk(clk), .rst(rst), .start(start), .signed_op(signed_op), .cancel(cancel),
      .a(a), .b(b), .busy(busy), .done(done), .lo(lo), .hi(hi), .div_zero(div_zero)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic launch(input logic s, input logic [31:0] av, input logic [31:0] bv);
      @(negedge clk);
      start = 1'b1; signed_op = s; a = av; b = bv;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Counts cycles after the accepting edge until done; optionally pokes start/a/b mid-operation.
   task automatic wait_done(input int poke_at, output int cyc, output int busy_cyc);
      cyc = 1; busy_cyc = 0;
      while (done !== 1'b1 && cyc < 100) begin
         if (busy === 1'b1) busy_cyc++;
         start = (cyc == poke_at);
         if (cyc == poke_at) begin a = 32'd7; b = 32'd1; signed_op = 1'b1; end
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
   endtask

   task automatic run(input string tag, input logic s, input logic [31:0] av, input logic [31:0] bv,
                      input logic [31:0] elo, input logic [31:0] ehi, input logic edz, input int elat);
      launch(s, av, bv);
      wait_done(0, n, bc);
      chk({tag, "_latency"}, n, elat);
      chk({tag, "_lo"}, lo, elo);
      chk({tag, "_hi"}, hi, ehi);
      chk({tag, "_dz"}, {31'd0, div_zero}, {31'd0, edz});
      chk({tag, "_busy_in_done"}, {31'd0, busy}, 32'd0);
   endtask

   initial begin
      repeat (2) @(negedge clk);
      rst = 1'b0;
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_lo", lo, 32'd0);
      chk("rst_hi", hi, 32'd0);
      chk("rst_dz", {31'd0, div_zero}, 32'd0);

      launch(1'b0, 32'd100, 32'd7);
      wait_done(0, n, bc);
      chk("divu_latency", n, 34);
      chk("divu_busy_cycles", bc, 33);
      chk("divu_lo", lo, 32'd14);
      chk("divu_hi", hi, 32'd2);
      chk("divu_dz", {31'd0, div_zero}, 32'd0);
      @(negedge clk);
      chk("divu_done_pulse", {31'd0, done}, 32'd0);
      chk("divu_lo_held", lo, 32'd14);

      run("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 34);
      run("div_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 1'b0, 34);
      run("div_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0, 34);
      run("divu_max", 1'b0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0, 34);
      run("divu_zero", 1'b0, 32'h1234, 32'd0, 32'hFFFFFFFF, 32'h1234, 1'b1, 1);
      run("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 34);

      // Cancel at CALC iteration 10 must leave the previous result untouched.
      launch(1'b0, 32'd50, 32'd5);
      repeat (10) @(negedge clk);
      cancel = 1'b1;
      @(negedge clk);
      cancel = 1'b0;
      chk("cancel_busy_drop", {31'd0, busy}, 32'd0);
      bc = 0;
      repeat (40) begin
         if (done === 1'b1) bc++;
         @(negedge clk);
      end
      chk("cancel_no_done", bc, 0);
      chk("cancel_lo_kept", lo, 32'd14);
      chk("cancel_hi_kept", hi, 32'd2);
      run("after_cancel", 1'b0, 32'd50, 32'd5, 32'd10, 32'd0, 1'b0, 34);

      // Operand changes and a start pulse mid-CALC are ignored.
      launch(1'b0, 32'd1000, 32'd3);
      wait_done(5, n, bc);
      chk("poke_latency", n, 34);
      chk("poke_lo", lo, 32'd333);
      chk("poke_hi", hi, 32'd1);
      // Start in the DONE cycle (would be a divide-by-zero) is ignored.
      start = 1'b1; a = 32'd20; b = 32'd0;
      @(negedge clk);
      start = 1'b0;
      chk("done_start_busy", {31'd0, busy}, 32'd0);
      bc = 0;
      repeat (5) begin
         if (done === 1'b1) bc++;
         @(negedge clk);
      end
      chk("done_start_no_done", bc, 0);
      chk("done_start_lo", lo, 32'd333);
      chk("done_start_dz", {31'd0, div_zero}, 32'd0);

      // Cancel together with start in IDLE: nothing accepted.
      @(negedge clk);
      start = 1'b1; cancel = 1'b1; a = 32'd9; b = 32'd3;
      @(negedge clk);
      start = 1'b0; cancel = 1'b0;
      chk("idle_cancel_busy", {31'd0, busy}, 32'd0);
      chk("idle_cancel_done", {31'd0, done}, 32'd0);

      // Reset mid-CALC clears everything.
      launch(1'b0, 32'd100, 32'd7);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_busy", {31'd0, busy}, 32'd0);
      chk("midrst_done", {31'd0, done}, 32'd0);
      chk("midrst_lo", lo, 32'd0);
      chk("midrst_hi", hi, 32'd0);
      chk("midrst_dz", {31'd0, div_zero}, 32'd0);
      bc = 0;
      repeat (40) begin
         if (done === 1'b1) bc++;
         @(negedge clk);
      end
      chk("midrst_no_done", bc, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
